// File: rtl/mem_port_arbiter.sv
// Purpose : shares one single-port, 1-cycle-read-latency RAM between the core port m0
//           (absolute priority) and a secondary requester m1 (valid/ready + rvalid).
// Latency : m0 is a combinational pass-through (zero added latency); m1 read accepted at t
//           reaches the RAM at t+1 and returns m1_rvalid/m1_rdata at t+2; m1 write hits RAM at t+1.
// Backpr. : m1_ready is high only in IDLE; an accepted m1 request waits (unbounded) while m0 is active.
//
// Ports   : clk/reset (async, active high); m0_* core port; m1_* secondary port;
//           s_* RAM side; stat_m1_grants / stat_m1_stalls statistics outputs.
// Option  : define MEM_ARB_STATS_EN to build saturating grant/stall counters;
//           without it both stat ports are constant zero.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int STAT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic              m0_rstrb,
  input  logic [31:0]       m0_wdata,
  input  logic [3:0]        m0_wmask,
  output logic [31:0]       m0_rdata,
  input  logic              m1_valid,
  output logic              m1_ready,
  input  logic              m1_rd,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [31:0]       m1_wdata,
  input  logic [3:0]        m1_wmask,
  output logic [31:0]       m1_rdata,
  output logic              m1_rvalid,
  output logic [ADDR_W-1:0] s_addr,
  output logic              s_rstrb,
  output logic [31:0]       s_wdata,
  output logic [3:0]        s_wmask,
  input  logic [31:0]       s_rdata,
  output logic [STAT_W-1:0] stat_m1_grants,
  output logic [STAT_W-1:0] stat_m1_stalls
);

  typedef enum logic [1:0] {IDLE, PEND, RESP} state_t;

  state_t              state_q, state_d;
  logic                hold_rd_q;
  logic [ADDR_W-1:0]   hold_addr_q;
  logic [31:0]         hold_wdata_q;
  logic [3:0]          hold_wmask_q;
  logic [31:0]         m1_rdata_q;

  logic m0_active;
  logic accept;   // m1 request captured this cycle
  logic grant;    // m1 owns the RAM this cycle
  logic stall;    // m1 pending but blocked by m0

  assign m0_active = m0_rstrb | (|m0_wmask);

  // The RAM holds its read data until the next strobe, so m0 simply watches it.
  assign m0_rdata = s_rdata;

  always_comb begin
    state_d  = state_q;
    m1_ready = 1'b0;
    accept   = 1'b0;
    grant    = 1'b0;
    stall    = 1'b0;
    s_addr   = m0_addr;
    s_wdata  = m0_wdata;
    s_rstrb  = m0_rstrb;
    s_wmask  = m0_wmask;

    case (state_q)
      IDLE: begin
        m1_ready = 1'b1;
        if (m1_valid) begin
          accept  = 1'b1;
          state_d = PEND;
        end
      end
      PEND: begin
        if (m0_active) begin
          stall = 1'b1;
        end else begin
          grant   = 1'b1;
          s_addr  = hold_addr_q;
          s_wdata = hold_wdata_q;
          if (hold_rd_q) begin
            // A read ignores any mask that came with the request.
            s_rstrb = 1'b1;
            s_wmask = 4'b0000;
            state_d = RESP;
          end else begin
            s_rstrb = 1'b0;
            s_wmask = hold_wmask_q;
            state_d = IDLE;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Reset blocks every RAM access and new m1 acceptance immediately, not at the next edge.
    if (reset) begin
      m1_ready = 1'b0;
      accept   = 1'b0;
      s_rstrb  = 1'b0;
      s_wmask  = 4'b0000;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      hold_rd_q    <= 1'b0;
      hold_addr_q  <= '0;
      hold_wdata_q <= '0;
      hold_wmask_q <= '0;
      m1_rdata_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        hold_rd_q    <= m1_rd;
        hold_addr_q  <= m1_addr;
        hold_wdata_q <= m1_wdata;
        hold_wmask_q <= m1_wmask;
      end
      if (state_q == RESP) begin
        m1_rdata_q <= s_rdata;
      end
    end
  end

  // In RESP the RAM output already carries the m1 result (m0 cannot disturb it until the
  // next edge), so it is presented directly; afterwards the captured copy is held.
  assign m1_rvalid = (state_q == RESP);
  assign m1_rdata  = (state_q == RESP) ? s_rdata : m1_rdata_q;

`ifdef MEM_ARB_STATS_EN
  logic [STAT_W-1:0] grants_q, stalls_q;
  localparam logic [STAT_W-1:0] STAT_ONE = {{(STAT_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grants_q <= '0;
      stalls_q <= '0;
    end else begin
      if (grant && (grants_q != '1)) grants_q <= grants_q + STAT_ONE;
      if (stall && (stalls_q != '1)) stalls_q <= stalls_q + STAT_ONE;
    end
  end

  assign stat_m1_grants = grants_q;
  assign stat_m1_stalls = stalls_q;
`else
  logic unused_stat_events;
  assign unused_stat_events = grant ^ stall;
  assign stat_m1_grants     = '0;
  assign stat_m1_stalls     = '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios followed by random traffic, all
// compared each cycle against a transaction-level reference model and a reference memory.
// Statistics expectations follow MEM_ARB_STATS_EN; STAT_W is shrunk to 4 to reach saturation.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] m0_addr;
  logic          m0_rstrb;
  logic [31:0]   m0_wdata;
  logic [3:0]    m0_wmask;
  logic [31:0]   m0_rdata;
  logic          m1_valid;
  logic          m1_ready;
  logic          m1_rd;
  logic [AW-1:0] m1_addr;
  logic [31:0]   m1_wdata;
  logic [3:0]    m1_wmask;
  logic [31:0]   m1_rdata;
  logic          m1_rvalid;
  logic [AW-1:0] s_addr;
  logic          s_rstrb;
  logic [31:0]   s_wdata;
  logic [3:0]    s_wmask;
  logic [31:0]   s_rdata;
  logic [SW-1:0] stat_m1_grants;
  logic [SW-1:0] stat_m1_stalls;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .STAT_W(SW)) dut (
    .clk(clk), .reset(reset),
    .m0_addr(m0_addr), .m0_rstrb(m0_rstrb), .m0_wdata(m0_wdata), .m0_wmask(m0_wmask),
    .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_rd(m1_rd), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_wmask(m1_wmask), .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid),
    .s_addr(s_addr), .s_rstrb(s_rstrb), .s_wdata(s_wdata), .s_wmask(s_wmask), .s_rdata(s_rdata),
    .stat_m1_grants(stat_m1_grants), .stat_m1_stalls(stat_m1_stalls)
  );

  function automatic logic [31:0] init_word(input int i);
    if (i == 4) return 32'hDEADBEEF;
    if (i == 8) return 32'h12345678;
    return 32'h9E3779B9 * 32'(i + 1);
  endfunction

  // Physical RAM: 64 words, 1-cycle read latency, output held between strobes.
  logic [31:0] ram [0:63];
  logic [31:0] ram_rdata_q = '0;
  bit          ram_loaded  = 1'b0;
  assign s_rdata = ram_rdata_q;

  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int i = 0; i < 64; i++) ram[i] <= init_word(i);
      ram_loaded <= 1'b1;
    end else begin
      if (s_rstrb) ram_rdata_q <= ram[s_addr[7:2]];
      for (int b = 0; b < 4; b++)
        if (s_wmask[b]) ram[s_addr[7:2]][8*b +: 8] <= s_wdata[8*b +: 8];
    end
  end

  // Reference model: one outstanding m1 transaction owns the m1 side from acceptance until
  // its RAM slot (and, for reads, the following response cycle).
  logic [31:0] ref_mem [0:63];
  bit          busy;
  bit          req_rd;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wmask;
  bit          resp_due;
  logic [31:0] resp_val, last_m1_rdata;
  bit          m0_rd_prev;
  logic [31:0] m0_rd_val;
  int          n_grants, n_stalls;
  int          checks, errors;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] sat(input int n);
    return (n > 15) ? 32'd15 : 32'(n);
  endfunction

  task automatic ref_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    for (int b = 0; b < 4; b++)
      if (m[b]) ref_mem[a[7:2]][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic check_stats();
`ifdef MEM_ARB_STATS_EN
    chk("stat_grants", 32'(stat_m1_grants), sat(n_grants));
    chk("stat_stalls", 32'(stat_m1_stalls), sat(n_stalls));
`else
    chk("stat_grants_off", 32'(stat_m1_grants), 32'd0);
    chk("stat_stalls_off", 32'(stat_m1_stalls), 32'd0);
`endif
  endtask

  // One clock cycle: compare at the falling edge, advance the model, return just after the rising edge.
  task automatic step();
    bit m0_act, slot, ready_exp;
    @(negedge clk);
    m0_act = m0_rstrb || (m0_wmask != 4'b0000);
    if (reset) begin
      chk("rst_s_rstrb", 32'(s_rstrb), 32'd0);
      chk("rst_s_wmask", 32'(s_wmask), 32'd0);
      chk("rst_m1_ready", 32'(m1_ready), 32'd0);
      chk("rst_m1_rvalid", 32'(m1_rvalid), 32'd0);
      chk("rst_m1_rdata", m1_rdata, 32'd0);
      busy = 0; resp_due = 0; last_m1_rdata = '0; m0_rd_prev = 0;
      n_grants = 0; n_stalls = 0;
      check_stats();
    end else begin
      ready_exp = !busy && !resp_due;
      slot      = busy && !m0_act;
      chk("m1_ready", 32'(m1_ready), 32'(ready_exp));
      chk("m1_rvalid", 32'(m1_rvalid), 32'(resp_due));
      chk("m1_rdata", m1_rdata, resp_due ? resp_val : last_m1_rdata);
      if (m0_rd_prev) chk("m0_rdata", m0_rdata, m0_rd_val);
      if (slot) begin
        chk("slot_addr", s_addr, req_addr);
        chk("slot_wdata", s_wdata, req_wdata);
        chk("slot_rstrb", 32'(s_rstrb), 32'(req_rd));
        chk("slot_wmask", 32'(s_wmask), req_rd ? 32'd0 : 32'(req_wmask));
      end else begin
        chk("pass_addr", s_addr, m0_addr);
        chk("pass_wdata", s_wdata, m0_wdata);
        chk("pass_rstrb", 32'(s_rstrb), 32'(m0_rstrb));
        chk("pass_wmask", 32'(s_wmask), 32'(m0_wmask));
      end
      check_stats();
      // advance
      if (resp_due) last_m1_rdata = resp_val;
      resp_due   = 0;
      m0_rd_prev = 0;
      if (slot) begin
        n_grants++;
        busy = 0;
        if (req_rd) begin
          resp_due = 1;
          resp_val = ref_mem[req_addr[7:2]];
        end else begin
          ref_write(req_addr, req_wdata, req_wmask);
        end
      end else if (busy) begin
        n_stalls++;
      end else if (ready_exp && m1_valid) begin
        busy = 1; req_rd = m1_rd; req_addr = m1_addr; req_wdata = m1_wdata; req_wmask = m1_wmask;
      end
      if (m0_act) begin
        if (m0_rstrb) begin
          m0_rd_prev = 1;
          m0_rd_val  = ref_mem[m0_addr[7:2]];
        end
        ref_write(m0_addr, m0_wdata, m0_wmask);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_m0(input bit rs, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    m0_rstrb = rs; m0_addr = a; m0_wdata = d; m0_wmask = m;
  endtask

  task automatic set_m1(input bit v, input bit rd, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] m);
    m1_valid = v; m1_rd = rd; m1_addr = a; m1_wdata = d; m1_wmask = m;
  endtask

  task automatic idle_all();
    set_m0(0, 32'h0, 32'h0, 4'h0);
    set_m1(0, 0, 32'h0, 32'h0, 4'h0);
  endtask

  task automatic do_reset();
    idle_all();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  logic [31:0] exp_sat;

  initial begin
    checks = 0; errors = 0;
    for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
    busy = 0; resp_due = 0; last_m1_rdata = '0; m0_rd_prev = 0; n_grants = 0; n_stalls = 0;
    req_rd = 0; req_addr = '0; req_wdata = '0; req_wmask = '0; resp_val = '0; m0_rd_val = '0;
    do_reset();

    // m0-only read of 0x10
    set_m0(1, 32'h10, 32'h0, 4'h0);
    #1;
    chk("tp1_s_rstrb", 32'(s_rstrb), 32'd1);
    chk("tp1_s_addr", s_addr, 32'h10);
    step();
    idle_all();
    #1;
    chk("tp1_m0_rdata", m0_rdata, 32'hDEADBEEF);
    chk("tp1_m1_rvalid", 32'(m1_rvalid), 32'd0);
    step();

    // m1 read of 0x20 with m0 idle
    set_m1(1, 1, 32'h20, 32'h0, 4'h0);
    #1;
    chk("tp2_ready_t", 32'(m1_ready), 32'd1);
    step();
    idle_all();
    #1;
    chk("tp2_s_rstrb", 32'(s_rstrb), 32'd1);
    chk("tp2_s_addr", s_addr, 32'h20);
    chk("tp2_ready_t1", 32'(m1_ready), 32'd0);
    step();
    #1;
    chk("tp2_rvalid", 32'(m1_rvalid), 32'd1);
    chk("tp2_rdata", m1_rdata, 32'h12345678);
    chk("tp2_ready_t2", 32'(m1_ready), 32'd0);
    step();

    // conflict: m1 read waits three m0-busy cycles
    do_reset();
    set_m1(1, 1, 32'h08, 32'h0, 4'h0);
    step();
    set_m1(0, 0, 32'h0, 32'h0, 4'h0);
    for (int k = 0; k < 3; k++) begin
      set_m0(1, 32'h40 + 32'(4 * k), 32'h0, 4'h0);
      #1;
      chk("tp3_m0_owns", s_addr, 32'h40 + 32'(4 * k));
      step();
    end
    idle_all();
    #1;
    chk("tp3_slot_addr", s_addr, 32'h08);
    step();
`ifdef MEM_ARB_STATS_EN
    chk("tp3_stalls", 32'(stat_m1_stalls), 32'd3);
    chk("tp3_grants", 32'(stat_m1_grants), 32'd1);
`endif
    step();

    // m1 byte write to 0x24, then m0 readback
    set_m1(1, 0, 32'h24, 32'h000000AB, 4'b0001);
    step();
    idle_all();
    #1;
    chk("tp4_s_wmask", 32'(s_wmask), 32'h1);
    chk("tp4_s_addr", s_addr, 32'h24);
    step();
    set_m0(1, 32'h24, 32'h0, 4'h0);
    #1;
    chk("tp4_no_rvalid", 32'(m1_rvalid), 32'd0);
    step();
    idle_all();
    #1;
    chk("tp4_byte0", m0_rdata & 32'hFF, 32'hAB);
    step();

    // reset while m1 is pending behind a busy m0
    set_m1(1, 1, 32'h30, 32'h0, 4'h0);
    step();
    set_m1(0, 0, 32'h0, 32'h0, 4'h0);
    set_m0(0, 32'h34, 32'hCAFEF00D, 4'hF);
    step();
    reset = 1'b1;
    #1;
    chk("tp5_s_rstrb", 32'(s_rstrb), 32'd0);
    chk("tp5_s_wmask", 32'(s_wmask), 32'd0);
    step();
    reset = 1'b0;
    idle_all();
    #1;
    chk("tp5_ready", 32'(m1_ready), 32'd1);
    repeat (3) step();

    // stall counter saturation (4-bit counters)
    set_m1(1, 1, 32'h0C, 32'h0, 4'h0);
    step();
    set_m1(0, 0, 32'h0, 32'h0, 4'h0);
    for (int k = 0; k < 20; k++) begin
      set_m0(1, 32'h50, 32'h0, 4'h0);
      step();
    end
`ifdef MEM_ARB_STATS_EN
    exp_sat = 32'd15;
`else
    exp_sat = 32'd0;
`endif
    chk("tp6_stall_sat", 32'(stat_m1_stalls), exp_sat);
    idle_all();
    repeat (3) step();

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 3))
        0: set_m0(1, {24'h0, 6'($urandom_range(0, 63)), 2'b00}, $urandom, 4'h0);
        1: set_m0(0, {24'h0, 6'($urandom_range(0, 63)), 2'b00}, $urandom, 4'($urandom_range(0, 15)));
        default: set_m0(0, {24'h0, 6'($urandom_range(0, 63)), 2'b00}, $urandom, 4'h0);
      endcase
      set_m1(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             {24'h0, 6'($urandom_range(0, 63)), 2'b00}, $urandom, 4'($urandom_range(0, 15)));
      step();
    end
    idle_all();
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port, 1-cycle-read-latency RAM between the RV32 core memory port (m0) and a secondary requester (m1), e.g. a DMA or debug loader.
- m0 has absolute priority and sees zero added latency, because the core has no stall input.
- m1 uses a valid/ready request plus an rvalid response and is served only in cycles where m0 is idle.
- Sits between the Processor and the system RAM in the SoC top.

Parameters:
ADDR_W, 32, address width for m0, m1 and the slave.
STAT_W, 16, width of the statistics counters (used only with the optional feature).

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
m0_addr  in  ADDR_W  core address
m0_rstrb  in  1  core read strobe (1-cycle pulse)
m0_wdata  in  32  core write data
m0_wmask  in  4  core byte write mask
m0_rdata  out  32  core read data
m1_valid  in  1  m1 request valid
m1_ready  out  1  m1 request accepted when valid&ready
m1_rd  in  1  1=read, 0=write
m1_addr  in  ADDR_W  m1 address
m1_wdata  in  32  m1 write data
m1_wmask  in  4  m1 byte write mask
m1_rdata  out  32  m1 read data, registered
m1_rvalid  out  1  1-cycle pulse, m1_rdata valid
s_addr  out  ADDR_W  RAM address
s_rstrb  out  1  RAM read strobe
s_wdata  out  32  RAM write data
s_wmask  out  4  RAM byte write mask
s_rdata  in  32  RAM read data; updated the cycle after s_rstrb, held otherwise
stat_m1_grants  out  STAT_W  number of RAM slots given to m1
stat_m1_stalls  out  STAT_W  cycles m1 waited on m0

Behaviour:
- m0_active = m0_rstrb | (|m0_wmask).
- m0 path is combinational pass-through. When m0_active, s_* are driven from m0_* in the same cycle.
- m0_rdata = s_rdata at all times. It is valid in the cycle after m0_rstrb.
- FSM states: IDLE, PEND, RESP. Reset state is IDLE.
- IDLE:
  - m1_ready = 1.
  - On m1_valid: capture m1_rd/addr/wdata/wmask into holding registers and go to PEND.
  - No slave access by m1 in the accept cycle.
- PEND:
  - m1_ready = 0.
  - If m0_active: hold, and stall counter +1.
  - Else drive s_* from the holding registers; grant counter +1.
    - If rd: s_rstrb = 1, s_wmask = 0, go to RESP.
    - If write: s_rstrb = 0, s_wmask = held mask, go to IDLE.
- RESP:
  - m1_ready = 0.
  - m1_rdata <= s_rdata, m1_rvalid = 1 for exactly this cycle's output edge; then go to IDLE.
  - m0 may issue in RESP; no conflict, because s_rdata still holds the m1 result.
- Latencies:
  - Minimum m1 read: accept at t, s_rstrb at t+1, m1_rvalid/m1_rdata at t+2.
  - Minimum m1 write: RAM write at t+1; the next accept is possible at t+2.
- m1_rd=1 with nonzero wmask: read wins and the mask is ignored. m1_rd=0 with wmask=0: no-op slot, still counted as a grant.
- When no m1 slot is active, s_addr/s_wdata default to m0_addr/m0_wdata, and s_rstrb/s_wmask follow m0.
- Reset (asynchronous, any state):
  - FSM goes to IDLE, holding registers clear, m1_rdata=0, m1_rvalid=0, counters=0.
  - s_rstrb and s_wmask are forced to 0 while reset is high; m1_ready=0 while reset is high.
  - A pending m1 transaction is dropped with no RAM access and no rvalid.
- Starvation is tolerated: the core idles in decode/execute states, which guarantees m1 slots.

Optional Feature:
- MEM_ARB_STATS_EN defined:
  - stat_m1_grants increments on each m1 RAM slot.
  - stat_m1_stalls increments on each PEND cycle with m0_active.
  - Both saturate at all-ones and clear on reset.
- Undefined: both stat ports are tied to 0 and no counter logic is built.

Test Plan:
- m0-only read: RAM[0x10]=0xDEADBEEF, m0_rstrb with addr 0x10 at t -> s_rstrb=1, s_addr=0x10 at t; m0_rdata=0xDEADBEEF at t+1; m1 outputs idle.
- m1 read, m0 idle: m1_valid at t, addr 0x20, RAM[0x20]=0x12345678 -> s_rstrb at t+1 with s_addr=0x20; m1_rvalid=1, m1_rdata=0x12345678 at t+2; m1_ready=0 during t+1..t+2.
- Conflict: accept m1 read, then m0_active for 3 cycles -> no m1 slave access during those cycles; m1 slot in the first m0-idle cycle; stat_m1_stalls=3, stat_m1_grants=1 (stats on).
- m1 byte write: addr 0x24, wdata 0x000000AB, wmask 0001 -> one cycle with s_wmask=0001; no rvalid; m0 readback of 0x24 shows byte 0 = 0xAB.
- Reset mid-PEND: reset asserted while in PEND with m0 busy -> s_rstrb and s_wmask 0 immediately; after release, m1_ready=1; no m1_rvalid, counters 0.
- Saturation with STAT_W=4: 20 stall cycles -> stat_m1_stalls=15. Without MEM_ARB_STATS_EN, both stat ports read 0.
